// File: rtl/axi4_slave_read_responder.sv
// AXI4 slave read responder: accepts AR requests and returns FIXED/INCR/WRAP
// read bursts from an internal word memory that a backdoor port can preload.
module axi4_slave_read_responder #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned MEM_DEPTH     = 256
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [ADDRESS_WIDTH-1:0]     araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]        bd_wdata
);

  localparam int unsigned AW     = ADDRESS_WIDTH;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                  state_q;
  logic                    arready_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  logic [1:0]              rresp_q;
  logic [ID_WIDTH-1:0]     rid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [AW-1:0]           addr_q;
  logic [AW-1:0]           wmask_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    berr_q;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    ar_hs;
  logic                    r_hs;
  logic                    wrap_len_ok;
  logic                    ar_err;
  logic [AW-1:0]           ar_wmask;
  logic [AW-1:0]           bytes_cur;
  logic [AW-1:0]           aligned_cur;
  logic [AW-1:0]           step_cur;
  logic [AW-1:0]           next_addr;
  logic [AW-1:0]           load_addr;
  logic [AW-1:0]           word_addr;
  logic                    load_berr;
  logic                    load_oob;
  logic                    load_err;
  logic [7:0]              beat_d;
  logic                    rlast_d;
  logic [1:0]              rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  // Beat address generation and output-register load values
  always_comb begin
    ar_hs       = arvalid && arready_q && (state_q == S_IDLE);
    r_hs        = rvalid_q && rready;

    bytes_cur   = AW'(1) << size_q;
    aligned_cur = addr_q & ~(bytes_cur - AW'(1));
    step_cur    = aligned_cur + bytes_cur;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      // The container base is unchanged across a wrap burst, so keep the high bits.
      BURST_WRAP:  next_addr = (addr_q & ~wmask_q) | (step_cur & wmask_q);
      default:     next_addr = step_cur;
    endcase

    wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
    ar_err      = (32'(arsize) > OFFS) || (arburst == BURST_RSVD) ||
                  ((arburst == BURST_WRAP) && !wrap_len_ok);
    ar_wmask    = ((AW'(arlen) + AW'(1)) << arsize) - AW'(1);

    load_addr   = ar_hs ? araddr : next_addr;
    load_berr   = ar_hs ? ar_err : berr_q;
    word_addr   = load_addr >> OFFS;
    load_oob    = word_addr >= AW'(MEM_DEPTH);
    load_err    = load_berr || load_oob;

    beat_d      = ar_hs ? 8'd0 : beat_q + 8'd1;
    rlast_d     = (beat_d == (ar_hs ? arlen : len_q));
    rresp_d     = load_err ? RESP_SLVERR : RESP_OKAY;
    rdata_d     = load_err ? '0 : mem_q[IDX_W'(word_addr)];
  end

  // Backdoor preload port; memory is never reset
  always_ff @(posedge aclk) begin
    if (bd_we) begin
      mem_q[bd_addr] <= bd_wdata;
    end
  end

  // Control FSM with registered AR/R outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wmask_q   <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= BURST_FIXED;
      berr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            state_q   <= S_BURST;
            arready_q <= 1'b0;
            rid_q     <= arid;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            wmask_q   <= ar_wmask;
            berr_q    <= ar_err;
            addr_q    <= load_addr;
            beat_q    <= beat_d;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
          end
        end
        S_BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              state_q   <= S_IDLE;
              arready_q <= 1'b1;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
            end else begin
              addr_q    <= load_addr;
              beat_q    <= beat_d;
              rdata_q   <= rdata_d;
              rresp_q   <= rresp_d;
              rlast_q   <= rlast_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_slave_read_responder.sv
// Bench for axi4_slave_read_responder: directed and random bursts checked
// against an address/data model built from the burst rules.
module tb_axi4_slave_read_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned MD = 256;

  logic          aclk;
  logic          areset;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          bd_we;
  logic [7:0]    bd_addr;
  logic [DW-1:0] bd_wdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem_m [MD];
  logic [63:0] exp_d [$];
  logic [1:0]  exp_r [$];

  axi4_slave_read_responder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(MD)
  ) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats from the burst address rules, using plain integer arithmetic
  task automatic build_exp(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    longint unsigned a, bytes, cont, lower, al;
    bit berr;
    exp_d.delete();
    exp_r.delete();
    bytes = 64'd1 << size;
    cont  = (64'(len) + 64'd1) * bytes;
    lower = (64'(addr) / cont) * cont;
    berr  = (size > 3'd3) || (burst == 2'd3) ||
            ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    a = 64'(addr);
    for (int i = 0; i <= int'(len); i++) begin
      if (berr || (a / 8) >= MD) begin
        exp_d.push_back(64'd0);
        exp_r.push_back(2'b10);
      end else begin
        exp_d.push_back(mem_m[int'(a / 8)]);
        exp_r.push_back(2'b00);
      end
      al = (a / bytes) * bytes;
      case (burst)
        2'd0: a = a;
        2'd2: a = ((al + bytes) == (lower + cont)) ? lower : (al + bytes);
        default: a = (al + bytes) % (64'd1 << 32);
      endcase
    end
  endtask

  task automatic bd_write(input int idx, input logic [63:0] data);
    @(negedge aclk);
    bd_we = 1'b1; bd_addr = 8'(idx); bd_wdata = data;
    @(negedge aclk);
    bd_we = 1'b0;
    mem_m[idx] = data;
  endtask

  // mode 0: rready high, 1: random rready, 2: hold rready low 3 cycles on beat 1
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    int beat = 0;
    int cyc = 0;
    int stall = 0;
    bit held = 0;
    bit rr;
    logic [63:0] s_data;
    logic [1:0]  s_resp;
    logic [3:0]  s_id;
    logic        s_last;
    build_exp(addr, len, size, burst);
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    check("ar_ready_wait", 64'(arready), 64'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("first_beat_latency", 64'(rvalid), 64'd1);
    check("arready_busy", 64'(arready), 64'd0);
    cyc = 0;
    while (beat <= int'(len) && cyc < 3000) begin
      if (held && rvalid === 1'b1) begin
        check("stall_rdata", rdata, s_data);
        check("stall_rresp", 64'(rresp), 64'(s_resp));
        check("stall_rid", 64'(rid), 64'(s_id));
        check("stall_rlast", 64'(rlast), 64'(s_last));
      end
      case (mode)
        0: rr = 1'b1;
        1: rr = 1'($urandom_range(0, 1));
        default: rr = !(beat == 1 && stall < 3);
      endcase
      if (mode == 2 && !rr) stall++;
      rready = rr;
      if (rvalid !== 1'b1) begin
        check("rvalid_in_burst", 64'(rvalid), 64'd1);
      end else if (rr) begin
        check($sformatf("rdata_b%0d", beat), rdata, exp_d[beat]);
        check($sformatf("rresp_b%0d", beat), 64'(rresp), 64'(exp_r[beat]));
        check($sformatf("rid_b%0d", beat), 64'(rid), 64'(id));
        check($sformatf("rlast_b%0d", beat), 64'(rlast), 64'(beat == int'(len)));
        beat++;
        held = 0;
      end else begin
        held = 1;
        s_data = rdata; s_resp = rresp; s_id = rid; s_last = rlast;
      end
      @(negedge aclk);
      cyc++;
    end
    check("burst_done_in_budget", 64'(beat), 64'(int'(len) + 1));
    rready = 1'b0;
    check("rvalid_after_last", 64'(rvalid), 64'd0);
    check("arready_idle_gap", 64'(arready), 64'd1);
  endtask

  initial begin : main
    logic [63:0] old_w;
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int wl [4] = '{1, 3, 7, 15};

    areset = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
    arsize = '0; arburst = '0; rready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    #12;
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    check("arready_at_release", 64'(arready), 64'd0);
    @(negedge aclk);
    check("arready_after_edge", 64'(arready), 64'd1);

    for (int i = 0; i < int'(MD); i++) begin
      @(negedge aclk);
      bd_we = 1'b1; bd_addr = 8'(i); bd_wdata = 64'(i) * 64'h11;
      mem_m[i] = 64'(i) * 64'h11;
    end
    @(negedge aclk);
    bd_we = 1'b0;

    run_burst(4'd5, 32'h0,  8'd3, 3'd3, 2'b01, 0);
    run_burst(4'd1, 32'h18, 8'd3, 3'd3, 2'b10, 0);
    run_burst(4'd2, 32'h10, 8'd2, 3'd3, 2'b00, 0);
    run_burst(4'd5, 32'h0,  8'd3, 3'd3, 2'b01, 2);
    run_burst(4'd3, 32'((MD - 1) * 8), 8'd1, 3'd3, 2'b01, 0);
    run_burst(4'd4, 32'h0,  8'd3, 3'd4, 2'b01, 0);
    run_burst(4'd6, 32'h8,  8'd2, 3'd3, 2'b10, 0);
    run_burst(4'd7, 32'h0,  8'd255, 3'd3, 2'b01, 0);
    run_burst(4'd8, 32'h23, 8'd3, 3'd1, 2'b10, 1);

    // Backdoor write in the same cycle as the beat load returns the old word
    @(negedge aclk);
    check("arready_before_bd", 64'(arready), 64'd1);
    old_w = mem_m[5];
    arid = 4'd9; araddr = 32'h28; arlen = 8'd0; arsize = 3'd3; arburst = 2'b00; arvalid = 1'b1;
    bd_we = 1'b1; bd_addr = 8'd5; bd_wdata = 64'hDEAD_BEEF_0000_0005;
    @(negedge aclk);
    arvalid = 1'b0; bd_we = 1'b0;
    mem_m[5] = 64'hDEAD_BEEF_0000_0005;
    check("bd_same_cycle_rvalid", 64'(rvalid), 64'd1);
    check("bd_same_cycle_old_data", rdata, old_w);
    check("bd_same_cycle_rlast", 64'(rlast), 64'd1);
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("bd_same_cycle_done", 64'(rvalid), 64'd0);
    run_burst(4'd9, 32'h28, 8'd1, 3'd3, 2'b00, 0);

    // Reset pulse in the middle of a burst
    @(negedge aclk);
    arid = 4'd2; araddr = 32'h0; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    check("mid_rst_beat0", rdata, mem_m[0]);
    @(negedge aclk);
    rready = 1'b0;
    check("mid_rst_beat1_valid", 64'(rvalid), 64'd1);
    check("mid_rst_beat1", rdata, mem_m[1]);
    #2 areset = 1'b1;
    #1;
    check("mid_rst_rvalid_async", 64'(rvalid), 64'd0);
    check("mid_rst_rlast_async", 64'(rlast), 64'd0);
    check("mid_rst_arready_async", 64'(arready), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    check("mid_rst_arready_release", 64'(arready), 64'd0);
    @(negedge aclk);
    check("mid_rst_arready_edge", 64'(arready), 64'd1);
    check("mid_rst_no_rvalid", 64'(rvalid), 64'd0);
    run_burst(4'd3, 32'h0, 8'd3, 3'd3, 2'b01, 0);

    // Randomised bursts with occasional backdoor updates
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++)
          bd_write(int'($urandom_range(0, MD - 1)), {$urandom, $urandom});
      end
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      if (rb == 2'b10 && $urandom_range(0, 4) != 0) rl = 8'(wl[$urandom_range(0, 3)]);
      else rl = 8'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: ra = 32'($urandom_range(0, 2047));
        1: ra = 32'(MD * 8) - 32'($urandom_range(0, 64));
        2: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
        default: ra = 32'($urandom_range(0, 2047)) & ~32'h7;
      endcase
      run_burst(4'($urandom_range(0, 15)), ra, rl, rs, rb, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
